bus_req_initiator: RTL and testbench

Initiator side of the BW/BR/PW/PR/S command interface consumed by the `control` FSM. It accepts one memory-access request at a time from the core. It encodes the request as a one-hot command plus start strobe and tracks the 2-bit `status` returned by `control`. It retries on error, enforces a response timeout, and reports completion to the core with a single-cycle response pulse.

---
 rtl/bus_req_pkg.sv | 37 +++
 rtl/bus_req_initiator.sv | 101 ++++++++++
 tb/tb_bus_req_initiator.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_req_pkg.sv
// Shared types and constants for the BW/BR/PW/PR/S command initiator.
// Command one-hot bit order is {BW, BR, PW, PR}.
package bus_req_pkg;

  typedef enum logic [1:0] {
    READY = 2'b00,
    BUSY  = 2'b01,
    DONE  = 2'b10,
    ERROR = 2'b11
  } status_t;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    ISSUE,
    WAIT,
    RESP
  } init_state_t;

  localparam logic [3:0] CMD_BW = 4'b1000;
  localparam logic [3:0] CMD_BR = 4'b0100;
  localparam logic [3:0] CMD_PW = 4'b0010;
  localparam logic [3:0] CMD_PR = 4'b0001;

  function automatic logic [3:0] enc_cmd(
    input logic we,
    input logic is_byte
  );
    unique case (1'b1)
      we && is_byte:   enc_cmd = CMD_BW;
      !we && is_byte:  enc_cmd = CMD_BR;
      we && !is_byte:  enc_cmd = CMD_PW;
      default:         enc_cmd = CMD_PR;
    endcase
  endfunction

endpackage

// File: rtl/bus_req_initiator.sv
// Single-request initiator: one-hot command + start strobe, retry on
// error or timeout, one-cycle response pulse back to the core.
module bus_req_initiator
  import bus_req_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic       req_we,
  input  logic       req_byte,
  output logic       req_ready,
  output logic       BW,
  output logic       BR,
  output logic       PW,
  output logic       PR,
  output logic       S,
  input  logic [1:0] status,
  output logic       resp_valid,
  output logic       resp_err,
  output logic       resp_timeout
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  init_state_t   state;
  logic [3:0]    cmd;
  logic [2:0]    retry;
  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          tmo_q;

  status_t st;
  logic    tmo_hit;
  logic    active;

  assign st      = status_t'(status);
  assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign active  = (state == ARM) || (state == ISSUE)
                || (state == WAIT);

  // Every output is a decode of registered state only.
  assign req_ready    = (state == IDLE);
  assign {BW, BR, PW, PR} = active ? cmd : 4'b0000;
  assign S            = (state == ISSUE);
  assign resp_valid   = (state == RESP);
  assign resp_err     = (state == RESP) && err_q;
  assign resp_timeout = (state == RESP) && tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cmd   <= 4'b0000;
      retry <= 3'd0;
      tcnt  <= '0;
      err_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            cmd   <= enc_cmd(req_we, req_byte);
            retry <= 3'd0;
            state <= ARM;
          end
        end
        ARM: begin
          if (st == READY) state <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: begin
          tcnt <= tcnt + TW'(1);
          if (st == DONE) begin
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            state <= RESP;
          end else if (st == ERROR || tmo_hit) begin
            if (retry < 3'(MAX_RETRY)) begin
              retry <= retry + 3'd1;
              state <= ARM;
            end else begin
              err_q <= 1'b1;
              tmo_q <= (st != ERROR);
              state <= RESP;
            end
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_req_initiator.sv
// Directed bench: per-cycle vector table plus hand-written corner
// sequences (async reset abort, timeout, DONE vs timeout, RESP hold).
module tb_bus_req_initiator;

  localparam logic [1:0] SR = 2'b00;
  localparam logic [1:0] SB = 2'b01;
  localparam logic [1:0] SD = 2'b10;
  localparam logic [1:0] SE = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_we = 1'b0;
  logic req_byte = 1'b0;
  logic [1:0] status = SB;

  logic rdy0, bw0, br0, pw0, pr0, s0, rv0, er0, to0;
  logic rdy1, bw1, br1, pw1, pr1, s1, rv1, er1, to1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_req_initiator #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_byte(req_byte), .req_ready(rdy0),
    .BW(bw0), .BR(br0), .PW(pw0), .PR(pr0),
    .S(s0), .status(status),
    .resp_valid(rv0), .resp_err(er0),
    .resp_timeout(to0)
  );

  bus_req_initiator #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRY(0)
  ) dut_nr (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we),
    .req_byte(req_byte), .req_ready(rdy1),
    .BW(bw1), .BR(br1), .PW(pw1), .PR(pr1),
    .S(s1), .status(status),
    .resp_valid(rv1), .resp_err(er1),
    .resp_timeout(to1)
  );

  // {ready, BW, BR, PW, PR, S, resp_valid, resp_err, resp_timeout}
  logic [8:0] obs0, obs1;
  assign obs0 = {rdy0, bw0, br0, pw0, pr0, s0, rv0, er0, to0};
  assign obs1 = {rdy1, bw1, br1, pw1, pr1, s1, rv1, er1, to1};

  typedef struct {
    logic       v;
    logic       we;
    logic       b;
    logic [1:0] st;
    logic [8:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic v, input logic we, input logic b,
    input logic [1:0] st, input logic [8:0] exp
  );
    vec_t r;
    r.v = v; r.we = we; r.b = b; r.st = st; r.exp = exp;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Expected observation words.
  localparam logic [8:0] O_IDLE = 9'b1_0000_0_000;
  localparam logic [8:0] O_OK   = 9'b0_0000_0_100;
  localparam logic [8:0] O_ERR  = 9'b0_0000_0_110;
  localparam logic [8:0] O_TMO  = 9'b0_0000_0_111;

  function automatic logic [8:0] o_cmd(
    input logic [3:0] c, input logic s);
    return {1'b0, c, s, 3'b000};
  endfunction

  initial begin
    // BW, DONE on 3rd WAIT cycle
    tbl[0]  = mk(1, 1, 1, SR, o_cmd(4'b1000, 0));
    tbl[1]  = mk(0, 0, 0, SR, o_cmd(4'b1000, 1));
    tbl[2]  = mk(0, 0, 0, SB, o_cmd(4'b1000, 0));
    tbl[3]  = mk(0, 0, 0, SB, o_cmd(4'b1000, 0));
    tbl[4]  = mk(0, 0, 0, SB, o_cmd(4'b1000, 0));
    tbl[5]  = mk(0, 0, 0, SD, O_OK);
    tbl[6]  = mk(0, 1, 1, SR, O_IDLE);
    // PR, BUSY held 4 cycles in ARM
    tbl[7]  = mk(1, 0, 0, SB, o_cmd(4'b0001, 0));
    tbl[8]  = mk(1, 1, 1, SB, o_cmd(4'b0001, 0));
    tbl[9]  = mk(0, 0, 0, SB, o_cmd(4'b0001, 0));
    tbl[10] = mk(0, 0, 0, SB, o_cmd(4'b0001, 0));
    tbl[11] = mk(0, 0, 0, SB, o_cmd(4'b0001, 0));
    tbl[12] = mk(0, 0, 0, SR, o_cmd(4'b0001, 1));
    tbl[13] = mk(0, 0, 0, SB, o_cmd(4'b0001, 0));
    tbl[14] = mk(0, 0, 0, SD, O_OK);
    tbl[15] = mk(0, 0, 0, SB, O_IDLE);
    // BR, ERROR on every attempt, two retries
    tbl[16] = mk(1, 0, 1, SR, o_cmd(4'b0100, 0));
    tbl[17] = mk(0, 0, 0, SR, o_cmd(4'b0100, 1));
    tbl[18] = mk(0, 0, 0, SE, o_cmd(4'b0100, 0));
    tbl[19] = mk(0, 0, 0, SE, o_cmd(4'b0100, 0));
    tbl[20] = mk(0, 0, 0, SR, o_cmd(4'b0100, 1));
    tbl[21] = mk(0, 0, 0, SB, o_cmd(4'b0100, 0));
    tbl[22] = mk(0, 0, 0, SE, o_cmd(4'b0100, 0));
    tbl[23] = mk(0, 0, 0, SR, o_cmd(4'b0100, 1));
    tbl[24] = mk(0, 0, 0, SB, o_cmd(4'b0100, 0));
    tbl[25] = mk(0, 0, 0, SE, O_ERR);
    tbl[26] = mk(0, 0, 0, SB, O_IDLE);

    #1;
    chk("reset_main", obs0, O_IDLE);
    chk("reset_noretry", obs1, O_IDLE);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      req_valid = tbl[i].v;
      req_we    = tbl[i].we;
      req_byte  = tbl[i].b;
      status    = tbl[i].st;
      step();
      chk($sformatf("vec%0d", i), obs0, tbl[i].exp);
    end

    // Async reset mid-WAIT of a BW transaction
    do_reset();
    req_valid = 1; req_we = 1; req_byte = 1;
    status = SR;
    step();
    req_valid = 0;
    step();
    status = SB;
    step();
    step();
    chk("pre_abort_bw", obs0, o_cmd(4'b1000, 0));
    #2 rst = 1'b1;
    #1 chk("abort_async", obs0, O_IDLE);
    #2 rst = 1'b0;
    status = SD;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("abort_idle%0d", i), obs0, O_IDLE);
    end

    // PW timeout, no retries, status stuck BUSY
    do_reset();
    req_valid = 1; req_we = 1; req_byte = 0;
    status = SR;
    step();
    req_valid = 0;
    step();
    chk("tmo_issue", obs1, o_cmd(4'b0010, 1));
    status = SB;
    step();
    for (int i = 1; i <= 15; i++) begin
      step();
      chk($sformatf("tmo_wait%0d", i), obs1,
          o_cmd(4'b0010, 0));
    end
    step();
    chk("tmo_resp", obs1, O_TMO);
    step();
    chk("tmo_idle", obs1, O_IDLE);

    // DONE on the final WAIT cycle beats timeout;
    // req_valid held through RESP is taken only in IDLE
    do_reset();
    req_valid = 1; req_we = 1; req_byte = 0;
    status = SR;
    step();
    step();
    status = SB;
    step();
    for (int i = 1; i <= 15; i++) step();
    chk("race_wait15", obs0, o_cmd(4'b0010, 0));
    status = SD;
    step();
    chk("race_resp", obs0, O_OK);
    status = SR;
    step();
    chk("hold_idle", obs0, O_IDLE);
    req_we = 0; req_byte = 1;
    step();
    chk("hold_accept", obs0, o_cmd(4'b0100, 0));
    req_valid = 0;

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
